// File: rtl/procesor_pkg.sv
// Shared definitions for the multi-cycle core: instruction fields, op codes,
// FSM states and flag bit positions.
package procesor_pkg;

    localparam int INS_W   = 26;
    localparam int OP_HI   = 25;
    localparam int OP_LO   = 22;
    localparam int REG_HI  = 21;
    localparam int REG_LO  = 17;
    localparam int SRC_BIT = 16;
    localparam int IMM_HI  = 15;
    localparam int IMM_LO  = 0;

    // flags_dbg layout is {V,N,C,Z}
    localparam int F_Z = 0;
    localparam int F_C = 1;
    localparam int F_N = 2;
    localparam int F_V = 3;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_LDA  = 4'h6,
        OP_STA  = 4'h7,
        OP_JMP  = 4'h8,
        OP_JZ   = 4'h9,
        OP_CALL = 4'hA,
        OP_RET  = 4'hB,
        OP_HALT = 4'hC
    } op_e;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_e;

endpackage

// File: rtl/procesor_mc_alu.sv
// alu_p: combinational ALU producing result and {V,N,C,Z}.
// LDA passes arg2 through so the core can reuse the Z/N computation.
module alu_p
    import procesor_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  op_e               op,
    input  logic [DATA_W-1:0] arg1,
    input  logic [DATA_W-1:0] arg2,
    output logic [DATA_W-1:0] res,
    output logic [3:0]        flags
);

    logic carry;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        res   = '0;
        carry = 1'b0;
        flags = '0;
        case (op)
            OP_ADD: begin
                {carry, res} = {1'b0, arg1} + {1'b0, arg2};
                flags[F_C]   = carry;
                flags[F_V]   = (arg1[DATA_W-1] == arg2[DATA_W-1]) && (res[DATA_W-1] != arg1[DATA_W-1]);
            end
            OP_SUB: begin
                // top bit of the widened difference is the borrow-out
                {carry, res} = {1'b0, arg1} - {1'b0, arg2};
                flags[F_C]   = carry;
                flags[F_V]   = (arg1[DATA_W-1] != arg2[DATA_W-1]) && (res[DATA_W-1] != arg1[DATA_W-1]);
            end
            OP_AND:  res = arg1 & arg2;
            OP_OR:   res = arg1 | arg2;
            OP_XOR:  res = arg1 ^ arg2;
            OP_LDA:  res = arg2;
            default: res = '0;
        endcase
        flags[F_Z] = (res == '0);
        flags[F_N] = res[DATA_W-1];
    end

endmodule

// File: rtl/procesor_mc.sv
// procesor_mc: multi-cycle FETCH/EXEC core with req/ack instruction port.
// Define PROC_LINK_STACK_EN for a LINK_DEPTH-entry call stack; otherwise a single link register.
module procesor_mc
    import procesor_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int NREGS      = 32,
    parameter int LINK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INS_W-1:0]  imem_rdata,
    input  logic              imem_ack,
    output logic              halted,
    output logic              stack_err,
    output logic [ADDR_W-1:0] pc_dbg,
    output logic [DATA_W-1:0] a_dbg,
    output logic [3:0]        flags_dbg
);

    state_e             state, state_next;
    logic [INS_W-1:0]   ir;
    logic [ADDR_W-1:0]  pc, pc_inc, pc_next, target, link_top;
    logic [DATA_W-1:0]  a, reg_rd, arg2, alu_res;
    logic [3:0]         flags, alu_flags;
    logic [4:0]         rsel;
    logic               rsel_ok, stack_fault;
    op_e                op;
    logic [DATA_W-1:0]  regs [NREGS];

    assign op      = op_e'(ir[OP_HI:OP_LO]);
    assign rsel    = ir[REG_HI:REG_LO];
    assign rsel_ok = int'(rsel) < NREGS;
    assign reg_rd  = rsel_ok ? regs[rsel] : '0;
    assign arg2    = ir[SRC_BIT] ? DATA_W'(ir[IMM_HI:IMM_LO]) : reg_rd;
    assign target  = ADDR_W'(ir[IMM_HI:IMM_LO]);
    assign pc_inc  = pc + ADDR_W'(1);

    alu_p #(.DATA_W(DATA_W)) u_alu (
        .op    (op),
        .arg1  (a),
        .arg2  (arg2),
        .res   (alu_res),
        .flags (alu_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        case (state)
            // gating with rst_n drops the request while reset is still asserted
            S_FETCH: begin
                imem_req = rst_n;
                if (imem_ack) state_next = S_EXEC;
            end
            S_EXEC:  state_next = (op == OP_HALT || stack_fault) ? S_HALT : S_FETCH;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
    end

    always_comb begin
        pc_next = pc_inc;
        case (op)
            OP_JMP:  pc_next = target;
            OP_JZ:   if (flags[F_Z]) pc_next = target;
            OP_CALL: pc_next = stack_fault ? pc : target;
            OP_RET:  pc_next = stack_fault ? pc : link_top;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir    <= '0;
            pc    <= '0;
            a     <= '0;
            flags <= '0;
        end else if (state == S_FETCH) begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            if (imem_ack) ir <= imem_rdata;
        end else if (state == S_EXEC) begin
            pc <= pc_next;
            case (op)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                    a     <= alu_res;
                    flags <= alu_flags;
                end
                OP_LDA: begin
                    a          <= alu_res;
                    flags[F_Z] <= alu_flags[F_Z];
                    flags[F_N] <= alu_flags[F_N];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register file must read zero after reset, so it is built from resettable flops.
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (state == S_EXEC && op == OP_STA && rsel_ok) begin
            regs[rsel] <= a;
        end
    end

`ifdef PROC_LINK_STACK_EN
    localparam int SP_W = $clog2(LINK_DEPTH + 1);

    // shift-register LIFO: entry 0 is always the top of stack
    logic [ADDR_W-1:0] link_mem [LINK_DEPTH];
    logic [SP_W-1:0]   sp;
    logic              err_q;

    assign stack_fault = (state == S_EXEC) &&
                         ((op == OP_CALL && sp == SP_W'(LINK_DEPTH)) || (op == OP_RET && sp == '0));
    assign link_top    = link_mem[0];
    assign stack_err   = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp    <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < LINK_DEPTH; i++) link_mem[i] <= '0;
        end else if (stack_fault) begin
            err_q <= 1'b1;
        end else if (state == S_EXEC && op == OP_CALL) begin
            link_mem[0] <= pc_inc;
            for (int i = 1; i < LINK_DEPTH; i++) link_mem[i] <= link_mem[i-1];
            sp <= sp + SP_W'(1);
        end else if (state == S_EXEC && op == OP_RET) begin
            for (int i = 0; i < LINK_DEPTH - 1; i++) link_mem[i] <= link_mem[i+1];
            link_mem[LINK_DEPTH-1] <= '0;
            sp <= sp - SP_W'(1);
        end
    end
`else
    logic [ADDR_W-1:0] link_reg;

    assign stack_fault = 1'b0;
    assign stack_err   = 1'b0;
    assign link_top    = link_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  link_reg <= '0;
        else if (state == S_EXEC && op == OP_CALL)   link_reg <= pc_inc;
    end
`endif

    assign halted    = (state == S_HALT);
    assign imem_addr = pc;
    assign pc_dbg    = pc;
    assign a_dbg     = a;
    assign flags_dbg = flags;

endmodule
